// File: rtl/byte_bus_target_if.sv
// Signal bundle between the CPU-bus host / memory side and byte_bus_target.
// The master modport is the host plus memory; the slave modport is the bridge.
interface byte_bus_target_if;
    logic        bus_sync;
    logic [7:0]  bus_addr_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        late_err;
    logic        overrun_err;

    modport master (
        output bus_sync, bus_addr_in, bus_data_in, mem_ready, mem_rdata,
        input  bus_data_out, bus_data_oe, mem_req, mem_we, mem_addr, mem_wdata,
        input  late_err, overrun_err
    );

    modport slave (
        input  bus_sync, bus_addr_in, bus_data_in, mem_ready, mem_rdata,
        output bus_data_out, bus_data_oe, mem_req, mem_we, mem_addr, mem_wdata,
        output late_err, overrun_err
    );
endinterface

// File: rtl/byte_bus_target.sv
// Target-side bridge for the 10-slot byte-serial CPU bus: deserialises a command
// per frame, runs it on a req/ready memory port and returns read data next frame.
module byte_bus_target #(
    parameter int unsigned FRAME_SLOTS = 10,
    parameter logic [7:0]  LATE_FILL   = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    byte_bus_target_if.slave bus
);
    localparam int unsigned SW = $clog2(FRAME_SLOTS);
    typedef logic [SW-1:0] slot_t;
    localparam slot_t LAST_SLOT = slot_t'(FRAME_SLOTS - 1);
    localparam slot_t CMD_SLOT  = slot_t'(5);
    localparam slot_t RSP_FIRST = slot_t'(6);
    localparam slot_t RSP_LAST  = slot_t'(9);

    typedef enum logic [1:0] {IDLE, PEND, HOLD} state_e;

    state_e      state_q, state_d;
    slot_t       slot_q, slot_d, cur_slot;
    logic        late_q, late_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] resp_q, resp_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        oe_q, oe_d;
    logic [7:0]  out_q, out_d;
    logic        late_err_q, late_err_d;
    logic        overrun_err_q, overrun_err_d;
    logic        set_resp;
    logic [1:0]  byte_sel;

    always_comb begin
        cur_slot      = bus.bus_sync ? '0 : slot_q;
        if (bus.bus_sync)
            slot_d = slot_t'(1);
        else if (slot_q == LAST_SLOT)
            slot_d = '0;
        else
            slot_d = slot_q + slot_t'(1);

        state_d       = state_q;
        late_d        = late_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        late_err_d    = 1'b0;
        overrun_err_d = 1'b0;
        set_resp      = 1'b0;

        if (state_q == PEND && bus.mem_ready) begin
            mem_req_d = 1'b0;
            late_d    = 1'b0;
            rdata_d   = mem_we_q ? rdata_q : bus.mem_rdata;
            state_d   = (mem_we_q || late_q) ? IDLE : HOLD;
        end

        for (int unsigned i = 0; i < 4; i++) begin
            if (cur_slot == slot_t'(i + 1)) begin
                addr_d[8*i +: 8]  = bus.bus_addr_in;
                wdata_d[8*i +: 8] = bus.bus_data_in;
            end
        end

        // Response bytes are snapshotted at the command slot, so HOLD is left here
        // and a new request may issue while the previous read is still returned.
        if (cur_slot == CMD_SLOT) begin
            if (state_q == HOLD) begin
                set_resp = 1'b1;
                resp_d   = rdata_q;
            end else if (state_q == PEND && !mem_we_q && !late_q) begin
                set_resp = 1'b1;
                if (bus.mem_ready) begin
                    resp_d = bus.mem_rdata;
                end else begin
                    resp_d     = {4{LATE_FILL}};
                    late_d     = 1'b1;
                    late_err_d = 1'b1;
                end
            end

            if (state_q == PEND && !bus.mem_ready) begin
                overrun_err_d = 1'b1;
            end else begin
                state_d     = PEND;
                late_d      = 1'b0;
                mem_req_d   = 1'b1;
                mem_we_d    = bus.bus_addr_in[0];
                mem_addr_d  = addr_q;
                mem_wdata_d = wdata_q;
            end
        end

        oe_d     = set_resp ||
                   (oe_q && !bus.bus_sync && slot_q >= RSP_FIRST && slot_q < RSP_LAST);
        byte_sel = 2'(slot_d - RSP_FIRST);
        out_d    = oe_d ? resp_d[{byte_sel, 3'b000} +: 8] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            late_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            resp_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            oe_q          <= 1'b0;
            out_q         <= '0;
            late_err_q    <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            late_q        <= late_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            resp_q        <= resp_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            oe_q          <= oe_d;
            out_q         <= out_d;
            late_err_q    <= late_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.bus_data_oe  = oe_q;
    assign bus.bus_data_out = out_q;
    assign bus.late_err     = late_err_q;
    assign bus.overrun_err  = overrun_err_q;
endmodule
